array_sched: RTL
================

ARRAY_SCHED -- requirements
Module: array_sched

Interface
REQ-001 SHALL have parameter HEIGHT, default 16, meaning array rows (ifm lanes).
REQ-002 SHALL have parameter WIDTH, default 16, meaning array columns (weight/ofm lanes).
REQ-003 SHALL have parameter CWIDTH, default 16, meaning width of the vector-count input.
REQ-004 SHALL have clk  input  1  single clock; one clock, all state on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  input  1  one-cycle job request, accepted only in IDLE.
REQ-007 SHALL have num_vec  input  CWIDTH  ifm vectors per job, sampled with start.
REQ-008 SHALL have abort  input  1  synchronous job cancel.
REQ-009 SHALL have busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have done  output  1  one-cycle pulse at job completion.
REQ-011 SHALL have en_i, clr_i  output  HEIGHT each  per-row ifm enable/clear into the array.
REQ-012 SHALL have en_w, clr_w  output  WIDTH each  per-column weight enable/clear.
REQ-013 SHALL have en_o, clr_o  output  WIDTH each  per-column ofm enable/clear at the bottom edge.
REQ-014 SHALL have ifm_rd, w_rd  output  1 each  fetch strobes to the ifm and weight buffers.
REQ-015 SHALL have perf_cycles  output  32  busy-cycle count (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with start=1 and num_vec!=0, latch num_vec and enter LOAD_W next cycle; start with num_vec=0 SHALL go directly to DONE.
REQ-018 SHALL hold LOAD_W for exactly HEIGHT cycles with en_w=all-ones and w_rd=1, clr_w=all-ones only in the first LOAD_W cycle.
REQ-019 SHALL hold STREAM for exactly num_vec+HEIGHT-1 cycles, stream cycle index t from 0.
REQ-020 SHALL assert en_i[h] iff h <= t < h+num_vec, and clr_i[h] iff t==h (row skew of one cycle per row).
REQ-021 SHALL assert ifm_rd iff t < num_vec.
REQ-022 SHALL, from STREAM cycle t==w onward, assert en_o[w] for num_vec+HEIGHT-1 consecutive cycles (continuing into DRAIN), clr_o[w] in the first of them.
REQ-023 SHALL hold DRAIN for exactly WIDTH+HEIGHT-1 cycles, then DONE for one cycle with done=1.
REQ-024 SHALL keep every en_*/clr_*/strobe output 0 outside the windows above.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort=1 in any non-IDLE state, force IDLE next cycle, drive all en_*/clr_*/strobes 0 that next cycle, and not pulse done; abort coincident with start in IDLE SHALL win (stay IDLE).
REQ-027 SHALL keep internal counters saturating-free: counter width CWIDTH+log2(HEIGHT+WIDTH)+1, no wrap for num_vec=2^CWIDTH-1.

Reset
REQ-028 SHALL, on rst_n low, asynchronously enter IDLE and drive busy, done, all en_*/clr_*, ifm_rd, w_rd to 0, perf_cycles to 0.
REQ-029 SHALL treat reset mid-job identical to power-on; no done pulse.

Configuration
REQ-030 SHALL, with macro ARRAY_SCHED_PERF_EN defined, increment perf_cycles each cycle busy=1, clear it on accepted start, wrap at 2^32.
REQ-031 SHALL, without ARRAY_SCHED_PERF_EN, drive perf_cycles constant 0 with no counter logic.

Structure
REQ-032 SHALL take the FSM state enum typedef and counter-width constant from shared package array_pkg.
REQ-033 SHALL instantiate sub-module skew_line (parameter N) twice: a one-cycle-per-lane delay chain generating en_i/clr_i from a single row-0 seed and en_o/clr_o from a single column-0 seed.

Verification (HEIGHT=WIDTH=16, CWIDTH=16)
REQ-034 SHALL check start, num_vec=4 -> LOAD_W 16 cycles, en_i[15] high STREAM cycles 15..18, done 1 cycle after 19+31 post-load cycles, busy span 67 cycles.
REQ-035 SHALL check start, num_vec=0 -> done next cycle, no en_*/clr_* ever high.
REQ-036 SHALL check abort in STREAM cycle 5 of num_vec=8 job -> all outputs 0 next cycle, no done, next start accepted normally.
REQ-037 SHALL check start pulsed during DRAIN -> ignored, single done pulse.
REQ-038 SHALL check rst_n low at STREAM cycle 3 -> outputs 0 asynchronously, FSM IDLE after release.
REQ-039 SHALL check with ARRAY_SCHED_PERF_EN, num_vec=4 -> perf_cycles=67 after done; without macro -> 0.

Source files
------------

// File: rtl/array_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : array_pkg                                                       |
// | Brief    : Shared scheduler state encoding and counter-width helper.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package array_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Wide enough that num_vec plus the array skew never wraps.
  function automatic int array_cnt_w(input int cwidth, input int height, input int width);
    return cwidth + $clog2(height + width) + 1;
  endfunction

endpackage : array_pkg

`default_nettype wire

// File: rtl/array_sched_skew_line.sv
// +----------------------------------------------------------------------------+
// | Module   : skew_line                                                       |
// | Brief    : One-cycle-per-lane delay chain fanning an enable/clear seed     |
// |            out across N lanes; lane 0 is the seed itself.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module skew_line #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         seed_en_i,
  input  logic         seed_clr_i,
  output logic [N-1:0] lane_en_o,
  output logic [N-1:0] lane_clr_o
);

  logic [N-2:0] en_q;
  logic [N-2:0] clr_q;

  assign lane_en_o  = {en_q, seed_en_i};
  assign lane_clr_o = {clr_q, seed_clr_i};

  // Flush empties the in-flight wavefront so a cancelled job leaves no tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= '0;
      clr_q <= '0;
    end else if (flush_i) begin
      en_q  <= '0;
      clr_q <= '0;
    end else begin
      en_q  <= lane_en_o[N-2:0];
      clr_q <= lane_clr_o[N-2:0];
    end
  end

endmodule : skew_line

`default_nettype wire

// File: rtl/array_sched.sv
// +----------------------------------------------------------------------------+
// | Module   : array_sched                                                     |
// | Brief    : Systolic-array job scheduler (weight load, skewed stream, drain)|
// |            Optional busy-cycle counter enabled by ARRAY_SCHED_PERF_EN.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module array_sched
  import array_pkg::*;
#(
  parameter int HEIGHT = 16,
  parameter int WIDTH  = 16,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CWIDTH-1:0] num_vec,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic              ifm_rd,
  output logic              w_rd,
  output logic [31:0]       perf_cycles
);

  localparam int CNT_W = array_cnt_w(CWIDTH, HEIGHT, WIDTH);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH + HEIGHT - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CWIDTH-1:0] nvec_q, nvec_d;

  logic [CNT_W-1:0]  w_nvec;
  logic [CNT_W-1:0]  w_stream_last;
  logic              w_row_seed_en;
  logic              w_col_seed_en;
  logic              w_clr_seed;

  assign w_nvec        = CNT_W'(nvec_q);
  assign w_stream_last = w_nvec + CNT_W'(HEIGHT - 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    nvec_d  = nvec_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          nvec_d  = num_vec;
          state_d = (num_vec == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: if (cnt_q == LOAD_LAST) begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: if (cnt_q == w_stream_last) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      S_DRAIN: if (cnt_q == DRAIN_LAST) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nvec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    w_rd          = (state_q == S_LOAD_W);
    en_w          = {WIDTH{state_q == S_LOAD_W}};
    clr_w         = {WIDTH{(state_q == S_LOAD_W) && (cnt_q == '0)}};
    ifm_rd        = (state_q == S_STREAM) && (cnt_q < w_nvec);
    w_row_seed_en = ifm_rd;
    w_clr_seed    = (state_q == S_STREAM) && (cnt_q == '0);
    w_col_seed_en = (state_q == S_STREAM);
  end

  // Column 0 accumulates for the whole stream; the skew carries it into drain.
  skew_line #(.N(HEIGHT)) u_row_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (abort),
    .seed_en_i  (w_row_seed_en),
    .seed_clr_i (w_clr_seed),
    .lane_en_o  (en_i),
    .lane_clr_o (clr_i)
  );

  skew_line #(.N(WIDTH)) u_col_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (abort),
    .seed_en_i  (w_col_seed_en),
    .seed_clr_i (w_clr_seed),
    .lane_en_o  (en_o),
    .lane_clr_o (clr_o)
  );

`ifdef ARRAY_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start && !abort) perf_d = '0;
    else if (state_q != S_IDLE)                 perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule : array_sched

`default_nettype wire
